// File: rtl/xform_scheduler.sv
// Sequences up to four programmed transform ops per point through an external graphics_transform datapath.
// Optional macro XFORM_SCHED_STATS_EN adds the pts_done output-handshake counter.
module xform_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_we,
    input  logic [1:0]                   cfg_addr,
    input  logic [1:0]                   cfg_type,
    input  logic [DATA_WIDTH-1:0]        cfg_param,
    input  logic [2:0]                   cfg_len,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_x,
    input  logic signed [DATA_WIDTH-1:0] in_y,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_x,
    output logic signed [DATA_WIDTH-1:0] out_y,
    output logic                         dp_start,
    output logic signed [DATA_WIDTH-1:0] dp_x,
    output logic signed [DATA_WIDTH-1:0] dp_y,
    output logic [DATA_WIDTH-1:0]        dp_param,
    output logic [1:0]                   dp_type,
    input  logic                         dp_done,
    input  logic signed [DATA_WIDTH-1:0] dp_x_res,
    input  logic signed [DATA_WIDTH-1:0] dp_y_res,
    output logic                         busy,
    output logic [2:0]                   dbg_state
`ifdef XFORM_SCHED_STATS_EN
    ,
    output logic [15:0]                  pts_done
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, NEXT, OUT} state_t;

    state_t                 state, state_n;
    logic [DATA_WIDTH-1:0]  fifo_x [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]  fifo_y [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          fifo_count;
    logic [2:0]             op_idx, len_q, len_in;
    logic [DATA_WIDTH-1:0]  work_x, work_y;
    logic [1:0]             slot_type  [4];
    logic [DATA_WIDTH-1:0]  slot_param [4];
    logic                   push, pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // A transfer happens on any rising edge where valid && ready are both high;
    // valid/data hold until it happens, and ready never depends on valid.
    assign in_ready  = (fifo_count < CW'(FIFO_DEPTH));
    assign push      = in_valid && in_ready;
    assign pop       = (state == LOAD);
    assign len_in    = (cfg_len > 3'd4) ? 3'd4 : cfg_len;

    assign busy      = (state != IDLE);
    assign dbg_state = state;
    assign out_valid = (state == OUT);
    assign out_x     = work_x;
    assign out_y     = work_y;
    assign dp_start  = (state == ISSUE);
    assign dp_x      = work_x;
    assign dp_y      = work_y;
    assign dp_type   = slot_type[op_idx[1:0]];
    assign dp_param  = slot_param[op_idx[1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_x[wr_ptr] <= in_x;
            fifo_y[wr_ptr] <= in_y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            op_idx     <= '0;
            len_q      <= '0;
            work_x     <= '0;
            work_y     <= '0;
            for (int i = 0; i < 4; i++) begin
                slot_type[i]  <= '0;
                slot_param[i] <= '0;
            end
        end else begin
            state <= state_n;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            // Program is frozen while a point is in flight.
            if (cfg_we && !busy) begin
                slot_type[cfg_addr]  <= cfg_type;
                slot_param[cfg_addr] <= cfg_param;
            end
            case (state)
                LOAD: begin
                    work_x <= fifo_x[rd_ptr];
                    work_y <= fifo_y[rd_ptr];
                    op_idx <= '0;
                    len_q  <= len_in;
                end
                WAIT: begin
                    if (dp_done) begin
                        work_x <= dp_x_res;
                        work_y <= dp_y_res;
                    end
                end
                NEXT:    op_idx <= op_idx + 3'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (fifo_count != '0) state_n = LOAD;
            LOAD:    state_n = (len_in == 3'd0) ? OUT : ISSUE;
            ISSUE:   state_n = WAIT;
            WAIT:    if (dp_done) state_n = NEXT;
            NEXT:    state_n = ((op_idx + 3'd1) == len_q) ? OUT : ISSUE;
            OUT:     if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

`ifdef XFORM_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) pts_done <= '0;
        else if (out_valid && out_ready) pts_done <= pts_done + 16'd1;
    end
`endif

endmodule

// File: tb/tb_xform_scheduler.sv
// Randomized bench for xform_scheduler: behavioural datapath responder, program-level reference model,
// expected-queue scoreboard with an independent output monitor.
module tb_xform_scheduler;
    localparam int DW = 16;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [1:0]    cfg_addr, cfg_type;
    logic [DW-1:0] cfg_param;
    logic [2:0]    cfg_len;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_x, in_y;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_x, out_y;
    logic          dp_start, dp_done;
    logic [DW-1:0] dp_x, dp_y, dp_param, dp_x_res, dp_y_res;
    logic [1:0]    dp_type;
    logic          busy;
    logic [2:0]    dbg_state;
`ifdef XFORM_SCHED_STATS_EN
    logic [15:0]   pts_done;
`endif

    xform_scheduler #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_type(cfg_type),
        .cfg_param(cfg_param), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
        .dp_start(dp_start), .dp_x(dp_x), .dp_y(dp_y), .dp_param(dp_param),
        .dp_type(dp_type), .dp_done(dp_done), .dp_x_res(dp_x_res), .dp_y_res(dp_y_res),
        .busy(busy), .dbg_state(dbg_state)
`ifdef XFORM_SCHED_STATS_EN
        , .pts_done(pts_done)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle++;

    // ---------------- scoreboard state ----------------
    logic [2*DW-1:0] exp_q[$];
    int              checks = 0;
    int              errors = 0;
    int              dp_starts = 0;
    int              last_acc_cycle = 0;
    logic [2*DW-1:0] last_out = '0;

    logic [1:0]      m_type  [4];
    logic [DW-1:0]   m_param [4];
    int              m_len = 0;

    bit              ready_rand = 1'b0;
    bit              ready_force = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Behaviour of the graphics_transform datapath: rotate by integer degrees
    // (quarter turns), Q8.8 scale of both axes, translate along x.
    function automatic logic [2*DW-1:0] apply_op(input logic [1:0] t,
                                                 input logic signed [DW-1:0] p,
                                                 input logic signed [DW-1:0] x,
                                                 input logic signed [DW-1:0] y);
        logic signed [2*DW-1:0] px, py;
        logic signed [DW-1:0]   nx, ny;
        int ang;
        nx = x;
        ny = y;
        case (t)
            2'b00: begin
                ang = int'(p) % 360;
                if (ang < 0) ang += 360;
                case (ang)
                    90:      begin nx = -y; ny = x;  end
                    180:     begin nx = -x; ny = -y; end
                    270:     begin nx = y;  ny = -x; end
                    default: ;
                endcase
            end
            2'b01: begin
                px = x * p;
                py = y * p;
                nx = px[DW+7:8];
                ny = py[DW+7:8];
            end
            2'b10: nx = x + p;
            default: ;
        endcase
        return {nx, ny};
    endfunction

    // Reference: the point runs through the first min(len,4) program slots in order.
    function automatic logic [2*DW-1:0] model_point(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [2*DW-1:0] r;
        int n;
        r = {x, y};
        n = (m_len > 4) ? 4 : m_len;
        for (int i = 0; i < n; i++)
            r = apply_op(m_type[i], m_param[i], r[2*DW-1:DW], r[DW-1:0]);
        return r;
    endfunction

    // ---------------- datapath responder ----------------
    initial begin
        logic [2*DW-1:0] r;
        logic [2+3*DW-1:0] ops;
        int n;
        dp_done = 1'b0;
        dp_x_res = '0;
        dp_y_res = '0;
        forever begin
            @(negedge clk);
            if (dp_start) begin
                dp_starts++;
                ops = {dp_type, dp_param, dp_x, dp_y};
                r = apply_op(dp_type, dp_param, dp_x, dp_y);
                n = $urandom_range(1, 4);
                @(negedge clk);
                check("dp_start_pulse", {63'd0, dp_start}, 64'd0);
                repeat (n - 1) @(negedge clk);
                if (busy) check("dp_hold", {14'd0, dp_type, dp_param, dp_x, dp_y}, {14'd0, ops});
                dp_done = 1'b1;
                dp_x_res = r[2*DW-1:DW];
                dp_y_res = r[DW-1:0];
                @(negedge clk);
                dp_done = 1'b0;
            end
        end
    end

    // ---------------- output ready driver ----------------
    always @(posedge clk) begin
        #2;
        out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    // ---------------- monitor ----------------
    bit              stall_pending = 1'b0;
    logic [2*DW-1:0] held = '0;
    always @(negedge clk) begin
        if (rst) begin
            stall_pending = 1'b0;
        end else begin
            if (stall_pending)
                check("out_hold", {31'd0, out_valid, out_x, out_y}, {31'd0, 1'b1, held});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %h with empty expected queue", {out_x, out_y});
                end else begin
                    check("out_point", {32'd0, out_x, out_y}, {32'd0, exp_q.pop_front()});
                end
                last_out = {out_x, out_y};
            end
            stall_pending = out_valid && !out_ready;
            held = {out_x, out_y};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic program_slot(input logic [1:0] a, input logic [1:0] t,
                                input logic [DW-1:0] p, input bit update_model);
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_type = t;
        cfg_param = p;
        @(negedge clk);
        cfg_we = 1'b0;
        if (update_model) begin
            m_type[a] = t;
            m_param[a] = p;
        end
    endtask

    task automatic set_len(input int l);
        cfg_len = 3'(l);
        m_len = l;
    endtask

    task automatic send_point(input logic [DW-1:0] x, input logic [DW-1:0] y);
        bit done;
        done = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        for (int i = 0; i < 300 && !done; i++) begin
            if (in_ready) begin
                exp_q.push_back(model_point(x, y));
                last_acc_cycle = cycle;
                done = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!done) fail_now("send_timeout");
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) fail_now("drain_timeout");
    endtask

    task automatic wait_dp_start();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (dp_start) done = 1'b1;
        end
        if (!done) fail_now("dp_start_timeout");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            m_type[i] = '0;
            m_param[i] = '0;
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int acc, start0, rise;
        bit seen;
        logic [DW-1:0] px [6];

        rst = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_type = '0; cfg_param = '0; cfg_len = '0;
        in_valid = 1'b0; in_x = '0; in_y = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin m_type[i] = '0; m_param[i] = '0; end
        repeat (3) @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_dp_start", {63'd0, dp_start}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid_after", {63'd0, out_valid}, 64'd0);

        // rotate 90 then translate
        program_slot(2'd0, 2'b00, 16'h005A, 1'b1);
        program_slot(2'd1, 2'b10, 16'h0500, 1'b1);
        set_len(2);
        start0 = dp_starts;
        send_point(16'h0A00, 16'h0000);
        wait_drain();
        check("rot_trans_out", {32'd0, last_out}, {32'd0, 16'h0500, 16'h0A00});
        check("rot_trans_starts", 64'(dp_starts - start0), 64'd2);

        // zero-length program: bypass with 2-cycle latency
        set_len(0);
        start0 = dp_starts;
        send_point(16'h0300, 16'h0400);
        seen = 1'b0;
        rise = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (out_valid) begin seen = 1'b1; rise = cycle; end
            else @(negedge clk);
        end
        if (!seen) fail_now("len0_out_timeout");
        else check("len0_latency", 64'(rise - (last_acc_cycle + 1)), 64'd2);
        wait_drain();
        check("len0_out", {32'd0, last_out}, {32'd0, 16'h0300, 16'h0400});
        check("len0_starts", 64'(dp_starts - start0), 64'd0);

        // back-pressure: 1 working + FD queued
        set_len(1);
        ready_force = 1'b0;
        for (int i = 0; i < 6; i++) px[i] = 16'(16'h0100 * (i + 1));
        acc = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (acc < 6) begin
                in_valid = 1'b1;
                in_x = px[acc];
                in_y = ~px[acc];
                if (in_ready) begin
                    exp_q.push_back(model_point(px[acc], ~px[acc]));
                    acc++;
                end
            end else in_valid = 1'b0;
        end
        check("bp_accepted", 64'(acc), 64'(FD + 1));
        check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        ready_force = 1'b1;
        for (int c = 0; c < 300 && acc < 6; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_x = px[acc];
            in_y = ~px[acc];
            if (in_ready) begin
                exp_q.push_back(model_point(px[acc], ~px[acc]));
                acc++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_all_accepted", 64'(acc), 64'd6);
        wait_drain();

        // config writes dropped while busy, honoured when idle
        program_slot(2'd0, 2'b10, 16'h0100, 1'b1);
        set_len(1);
        send_point(16'h0200, 16'h0300);
        wait_dp_start();
        program_slot(2'd0, 2'b01, 16'h0200, 1'b0);
        wait_drain();
        check("busy_write_dropped", {32'd0, last_out}, {32'd0, 16'h0300, 16'h0300});
        program_slot(2'd0, 2'b01, 16'h0200, 1'b1);
        send_point(16'h0500, 16'h0500);
        wait_drain();
        check("idle_write_scale", {32'd0, last_out}, {32'd0, 16'h0A00, 16'h0A00});

        // reset during WAIT abandons the point
        send_point(16'h1234, 16'h0042);
        wait_dp_start();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin m_type[i] = '0; m_param[i] = '0; end
        repeat (10) @(negedge clk);
        check("midrst_idle", {63'd0, busy}, 64'd0);
        program_slot(2'd0, 2'b10, 16'h0010, 1'b1);
        program_slot(2'd1, 2'b00, 16'h00B4, 1'b1);
        set_len(2);
        send_point(16'h0100, 16'h0200);
        wait_drain();
        check("midrst_fresh", {32'd0, last_out}, {32'd0, 16'hFEF0, 16'hFE00});

        // randomized programs and traffic
        ready_rand = 1'b1;
        for (int b = 0; b < 6; b++) begin
            for (int s = 0; s < 4; s++) begin
                logic [1:0] t;
                logic [DW-1:0] p;
                t = 2'($urandom_range(0, 3));
                case (t)
                    2'b00:   p = 16'(90 * $urandom_range(0, 3));
                    2'b01:   p = 16'($urandom_range(16'h0040, 16'h0300));
                    default: p = 16'($urandom);
                endcase
                program_slot(2'(s), t, p, 1'b1);
            end
            set_len($urandom_range(0, 7));
            for (int k = 0; k < 8; k++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_point(16'($urandom), 16'($urandom));
            end
            wait_drain();
        end
        ready_rand = 1'b0;
        ready_force = 1'b1;

`ifdef XFORM_SCHED_STATS_EN
        do_reset();
        check("stats_rst", {48'd0, pts_done}, 64'd0);
        set_len(0);
        for (int k = 0; k < 3; k++) send_point(16'($urandom), 16'($urandom));
        wait_drain();
        check("stats_three", {48'd0, pts_done}, 64'd3);
        do_reset();
        check("stats_cleared", {48'd0, pts_done}, 64'd0);
`endif

        repeat (5) @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
